// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcode and branch condition-code encodings,
// plus the flag-update class used by the flag register.
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GTE    = 3'b100;
    localparam logic [2:0] CC_LTE    = 3'b101;
    localparam logic [2:0] CC_OVFL   = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    typedef enum logic [1:0] {
        FLG_NONE,
        FLG_Z,
        FLG_ZVN
    } flg_class_e;

endpackage

// File: rtl/flag_branch_unit_if.sv
// EX-stage / ID-branch bundle between the pipeline and the flag/branch unit.
// The pipeline side is the master; the flag unit is the slave.
interface flag_branch_unit_if #(
    parameter int WIDTH = 16
);
    logic             ex_valid;
    logic [3:0]       ex_opcode;
    logic [WIDTH-1:0] ex_result;
    logic             ex_ovfl;
    logic             stall;
    logic             flush;
    logic             br_valid;
    logic [2:0]       br_ccc;
    logic             br_taken;
    logic             flag_z;
    logic             flag_v;
    logic             flag_n;

    modport master (
        output ex_valid, ex_opcode, ex_result, ex_ovfl, stall, flush,
               br_valid, br_ccc,
        input  br_taken, flag_z, flag_v, flag_n
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_result, ex_ovfl, stall, flush,
               br_valid, br_ccc,
        output br_taken, flag_z, flag_v, flag_n
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: maps a 3-bit condition code and
// the Z/V/N flags to a single "condition holds" bit.
module branch_cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] i_ccc,
    input  logic       i_z,
    input  logic       i_v,
    input  logic       i_n,
    output logic       o_cond
);

    // NOTE: default assignment first so no path through the case leaves
    // o_cond unassigned, which would otherwise infer a latch.
    always_comb begin
        o_cond = 1'b0;
        case (i_ccc)
            CC_NE:     o_cond = ~i_z;
            CC_EQ:     o_cond = i_z;
            CC_GT:     o_cond = ~i_z & ~i_n;
            CC_LT:     o_cond = i_n;
            CC_GTE:    o_cond = i_z | ~i_n;
            CC_LTE:    o_cond = i_z | i_n;
            CC_OVFL:   o_cond = i_v;
            CC_UNCOND: o_cond = 1'b1;
            default:   o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural Z/V/N flag register with a same-cycle bypass from EX so a
// branch in ID directly behind a flag-setting instruction resolves correctly.
module flag_branch_unit
    import wisc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    flag_branch_unit_if.slave bus
);

    flg_class_e w_class;
    logic       w_upd;
    logic       w_wr;
    logic       w_z_new;
    logic       w_v_new;
    logic       w_n_new;
    logic       w_z_eff;
    logic       w_v_eff;
    logic       w_n_eff;
    logic       w_cond;
    logic       r_z;
    logic       r_v;
    logic       r_n;

    always_comb begin
        w_class = FLG_NONE;
        case (bus.ex_opcode)
            OP_ADD, OP_SUB:                 w_class = FLG_ZVN;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: w_class = FLG_Z;
            OP_RED, OP_PADDSB, OP_LW, OP_SW, OP_LLB, OP_LHB,
            OP_B, OP_BR, OP_PCS, OP_HLT:    w_class = FLG_NONE;
            default:                        w_class = FLG_NONE;
        endcase
    end

    assign w_z_new = (bus.ex_result == '0);
    assign w_n_new = bus.ex_result[WIDTH-1];
    assign w_v_new = bus.ex_ovfl;

    // Flush kills both the write and the bypass; stall only kills the write.
    assign w_upd = bus.ex_valid & ~bus.flush & (w_class != FLG_NONE);
    assign w_wr  = w_upd & ~bus.stall;

    assign w_z_eff = w_upd                       ? w_z_new : r_z;
    assign w_v_eff = (w_upd && w_class == FLG_ZVN) ? w_v_new : r_v;
    assign w_n_eff = (w_upd && w_class == FLG_ZVN) ? w_n_new : r_n;

    // NOTE: non-blocking assignments so every flag samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z <= 1'b0;
            r_v <= 1'b0;
            r_n <= 1'b0;
        end else if (w_wr) begin
            r_z <= w_z_new;
            if (w_class == FLG_ZVN) begin
                r_v <= w_v_new;
                r_n <= w_n_new;
            end
        end
    end

    branch_cond_eval u_cond (
        .i_ccc  (bus.br_ccc),
        .i_z    (w_z_eff),
        .i_v    (w_v_eff),
        .i_n    (w_n_eff),
        .o_cond (w_cond)
    );

    assign bus.br_taken = bus.br_valid & w_cond;
    assign bus.flag_z   = r_z;
    assign bus.flag_v   = r_v;
    assign bus.flag_n   = r_n;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: expected {br_taken, Z, V, N} tuples are
// queued as each step is driven and popped when the outputs are sampled.
module tb_flag_branch_unit;
    import wisc_pkg::*;

    typedef struct {
        string      tag;
        logic [3:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t exp_q[$];

    flag_branch_unit_if #(.WIDTH(16)) bus ();

    flag_branch_unit #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic cond_ref(input logic [2:0] cc, input logic z,
                                      input logic v, input logic n);
        case (cc)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return z || n;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic check_now(input string tag, input logic [3:0] exp_val);
        exp_t e;
        logic [3:0] obs;
        exp_q.push_back('{tag, exp_val});
        #1;
        e   = exp_q.pop_front();
        obs = {bus.br_taken, bus.flag_z, bus.flag_v, bus.flag_n};
        total++;
        assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s observed{taken,z,v,n}=%b expected=%b", e.tag, obs, e.val);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] op,
                        input logic [15:0] res, input logic ovf,
                        input logic st, input logic fl,
                        input logic bv, input logic [2:0] cc,
                        input string tag, input logic [3:0] exp_val);
        @(negedge clk);
        bus.ex_valid  = v;
        bus.ex_opcode = op;
        bus.ex_result = res;
        bus.ex_ovfl   = ovf;
        bus.stall     = st;
        bus.flush     = fl;
        bus.br_valid  = bv;
        bus.br_ccc    = cc;
        #1;
        check_now(tag, exp_val);
    endtask

    initial begin
        logic pv;
        logic pn;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.ex_valid  = 1'b0;
        bus.ex_opcode = OP_HLT;
        bus.ex_result = '0;
        bus.ex_ovfl   = 1'b0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_ccc    = CC_NE;

        // Reset state: flags zero, NE taken against all-zero flags
        step(0, OP_HLT, 16'h0000, 0, 0, 0, 1, CC_NE, "reset_ne", 4'b1000);
        step(0, OP_HLT, 16'h0000, 0, 0, 0, 1, CC_EQ, "reset_eq", 4'b0000);

        // Reset released with a write in EX; EQ taken via bypass
        rst_n = 1'b1;
        step(1, OP_ADD, 16'h0000, 0, 0, 0, 1, CC_EQ, "add0_bypass_eq", 4'b1000);
        step(0, OP_HLT, 16'h0000, 0, 0, 0, 1, CC_EQ, "add0_reg", 4'b1100);

        // SUB sets V,N; SLL writes Z only
        step(1, OP_SUB, 16'h8000, 1, 0, 0, 1, CC_OVFL, "sub_bypass_ovfl", 4'b1100);
        step(1, OP_SLL, 16'h0000, 0, 0, 0, 1, CC_LT, "sll_lt_reg_n", 4'b1011);
        step(0, OP_HLT, 16'h0000, 0, 0, 0, 1, CC_GT, "sll_hold_vn", 4'b0111);

        // Non-writing opcodes leave flags alone
        step(1, OP_ADD, 16'h0001, 0, 0, 0, 1, CC_OVFL, "add1_bypass_v0", 4'b0111);
        step(1, OP_RED, 16'h0000, 0, 0, 0, 1, CC_GT, "red_gt", 4'b1000);
        step(1, OP_LW,  16'h0000, 1, 0, 0, 1, CC_EQ, "lw_eq", 4'b0000);
        step(1, OP_PCS, 16'h0000, 1, 0, 0, 1, CC_OVFL, "pcs_ovfl", 4'b0000);

        // Stall holds the flags but the bypass is still live
        step(1, OP_ADD, 16'hFFFF, 0, 1, 0, 1, CC_LT, "stall1_lt", 4'b1000);
        step(1, OP_ADD, 16'hFFFF, 0, 1, 0, 1, CC_LT, "stall2_lt", 4'b1000);
        step(1, OP_ADD, 16'hFFFF, 0, 0, 0, 1, CC_LT, "stall_rel_lt", 4'b1000);
        step(0, OP_HLT, 16'h0000, 0, 0, 0, 1, CC_LT, "stall_rel_reg", 4'b1001);

        // Flush blocks write and bypass; flush beats stall
        step(1, OP_SUB, 16'h0000, 0, 0, 1, 1, CC_EQ, "flush_eq", 4'b0001);
        step(0, OP_HLT, 16'h0000, 0, 0, 0, 1, CC_EQ, "flush_z_held", 4'b0001);
        step(1, OP_ADD, 16'h0000, 1, 1, 1, 1, CC_EQ, "flush_stall_eq", 4'b0001);
        step(0, OP_HLT, 16'h0000, 0, 0, 0, 1, CC_OVFL, "flush_stall_reg", 4'b0001);

        // Back-to-back setters overwrite; valid=0 and br_valid=0 do nothing
        step(1, OP_ADD, 16'h0000, 1, 0, 0, 0, CC_UNCOND, "b2b_add", 4'b0001);
        step(1, OP_XOR, 16'h0005, 0, 0, 0, 0, CC_UNCOND, "b2b_xor", 4'b0110);
        step(0, OP_ADD, 16'h8000, 0, 0, 0, 1, CC_NE, "b2b_final", 4'b1010);

        // Reset mid-operation drops the pending write
        step(1, OP_ADD, 16'h8000, 1, 0, 0, 0, CC_NE, "pre_async_rst", 4'b0010);
        #1;
        rst_n = 1'b0;
        check_now("async_rst_clear", 4'b0000);
        step(0, OP_HLT, 16'h0000, 0, 0, 0, 0, CC_NE, "async_rst_lost_wr", 4'b0000);
        rst_n = 1'b1;

        // Sweep ccc x ZVN: register V,N via ADD, then Z via stalled SLL bypass
        pv = 1'b0;
        pn = 1'b0;
        for (int bv = 1; bv >= 0; bv--) begin
            for (int combo = 0; combo < 8; combo++) begin
                logic z;
                logic v;
                logic n;
                z = combo[2];
                v = combo[1];
                n = combo[0];
                step(1, OP_ADD, n ? 16'h8000 : 16'h0001, v, 0, 0, 0, CC_UNCOND,
                     "sweep_setup", {1'b0, 1'b0, pv, pn});
                for (int cc = 0; cc < 8; cc++) begin
                    step(1, OP_SLL, z ? 16'h0000 : 16'h0001, 0, 1, 0,
                         bv[0], cc[2:0], $sformatf("sweep_bv%0d_zvn%0d_cc%0d", bv, combo, cc),
                         {bv[0] & cond_ref(cc[2:0], z, v, n), 1'b0, v, n});
                end
                pv = v;
                pn = n;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
